// File: rtl/frame_fwd_pkg.sv
// Shared types and sizing helpers for the store-and-forward frame FIFO.
package frame_fwd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    // Pointer width: address bits plus one wrap bit to tell full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/frame_fwd_ram.sv
// Simple dual-port register array: synchronous write, combinational read.
module frame_fwd_ram
    import frame_fwd_pkg::*;
#(
    parameter int W     = 9,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_fifo_fwd.sv
// Store-and-forward frame FIFO: buffers rx frames, forwards only complete ones
// with a fixed inter-frame gap, and drops whole frames that do not fit.
module frame_fifo_fwd
    import frame_fwd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int IFG    = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      rxd,
    input  logic                   rx_dv,
    output logic [DATA_W-1:0]      txd,
    output logic                   tx_en,
    output logic                   overflow,
    output logic [CNT_W-1:0]       frames_fwd,
    output logic [CNT_W-1:0]       frames_drop,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     cmt_frames_q, cmt_frames_d, level_q, level_d, occ_s;
    logic              armed_q, armed_d, discard_q, discard_d, hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d, txd_q, txd_d;
    logic              tx_en_q, tx_en_d, overflow_q, overflow_d;
    logic [CNT_W-1:0]  fwd_q, fwd_d, drop_q, drop_d;
    tx_state_t         state_q, state_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              we_s, ovf_s, cmt_inc_s, cmt_dec_s, load_s;
    fifo_entry_t       wentry_s, rentry_s;
    logic [DATA_W:0]   rdata_s;

    frame_fwd_ram #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wentry_s),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata_s)
    );

    assign rentry_s = rdata_s;
    assign occ_s    = wr_ptr_q - rd_ptr_q;
    assign ovf_s    = hold_vld_q && (occ_s == PW'(DEPTH));
    // SEND always has a committed entry waiting, so it loads unconditionally.
    assign load_s   = (state_q == SEND) || ((state_q == IDLE) && (cmt_frames_q != '0));

    // Receive path: arming, hold stage, speculative write and overflow rewind
    always_comb begin
        armed_d       = armed_q;
        discard_d     = discard_q;
        hold_vld_d    = 1'b0;
        hold_data_d   = hold_data_q;
        wr_ptr_d      = wr_ptr_q;
        wr_cmt_d      = wr_cmt_q;
        we_s          = 1'b0;
        cmt_inc_s     = 1'b0;
        overflow_d    = 1'b0;
        drop_d        = drop_q;
        wentry_s.last = !rx_dv;
        wentry_s.data = hold_data_q;
        if (ovf_s) begin
            wr_ptr_d   = wr_cmt_q;
            overflow_d = 1'b1;
            drop_d     = (drop_q == {CNT_W{1'b1}}) ? drop_q : drop_q + CNT_W'(1);
        end else if (hold_vld_q) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (!rx_dv) begin
                wr_cmt_d  = wr_ptr_q + PW'(1);
                cmt_inc_s = 1'b1;
            end else begin
                cmt_inc_s = 1'b0;
            end
        end else begin
            we_s = 1'b0;
        end
        // A frame already running when reset lifts is skipped until its end.
        if (!armed_q) begin
            armed_d = !rx_dv;
        end else if (ovf_s || discard_q) begin
            discard_d = rx_dv;
        end else begin
            discard_d  = 1'b0;
            hold_vld_d = rx_dv;
            if (rx_dv) begin
                hold_data_d = rxd;
            end else begin
                hold_data_d = hold_data_q;
            end
        end
    end

    // Tx FSM next-state and gap counter
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE, SEND: begin
                if (load_s && rentry_s.last) begin
                    state_d   = GAP;
                    gap_cnt_d = GW'(IFG - 1);
                end else if (load_s) begin
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tx FSM outputs: beat load, read pointer, forwarded-frame bookkeeping
    always_comb begin
        txd_d     = txd_q;
        tx_en_d   = 1'b0;
        rd_ptr_d  = rd_ptr_q;
        cmt_dec_s = 1'b0;
        fwd_d     = fwd_q;
        if (load_s) begin
            txd_d    = rentry_s.data;
            tx_en_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (rentry_s.last) begin
                cmt_dec_s = 1'b1;
                fwd_d     = (fwd_q == {CNT_W{1'b1}}) ? fwd_q : fwd_q + CNT_W'(1);
            end else begin
                cmt_dec_s = 1'b0;
            end
        end else begin
            tx_en_d = 1'b0;
        end
        cmt_frames_d = cmt_frames_q + PW'(cmt_inc_s) - PW'(cmt_dec_s);
        level_d      = wr_ptr_d - rd_ptr_d;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            wr_cmt_q     <= '0;
            rd_ptr_q     <= '0;
            cmt_frames_q <= '0;
            level_q      <= '0;
            armed_q      <= 1'b0;
            discard_q    <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_data_q  <= '0;
            txd_q        <= '0;
            tx_en_q      <= 1'b0;
            overflow_q   <= 1'b0;
            fwd_q        <= '0;
            drop_q       <= '0;
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_cmt_q     <= wr_cmt_d;
            rd_ptr_q     <= rd_ptr_d;
            cmt_frames_q <= cmt_frames_d;
            level_q      <= level_d;
            armed_q      <= armed_d;
            discard_q    <= discard_d;
            hold_vld_q   <= hold_vld_d;
            hold_data_q  <= hold_data_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            overflow_q   <= overflow_d;
            fwd_q        <= fwd_d;
            drop_q       <= drop_d;
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign txd         = txd_q;
    assign tx_en       = tx_en_q;
    assign overflow    = overflow_q;
    assign frames_fwd  = fwd_q;
    assign frames_drop = drop_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_frame_fifo_fwd.sv
// Randomised bench for frame_fifo_fwd against a queue-based frame model.
module tb_frame_fifo_fwd;

    localparam int DEPTH = 8;
    localparam int IFG   = 2;

    logic        clk, rst_n, rx_dv, tx_en, overflow;
    logic [7:0]  rxd, txd;
    logic [15:0] frames_fwd, frames_drop;
    logic [3:0]  fifo_level;

    frame_fifo_fwd #(.DATA_W(8), .DEPTH(DEPTH), .IFG(IFG), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_dv(rx_dv), .txd(txd), .tx_en(tx_en),
        .overflow(overflow), .frames_fwd(frames_fwd), .frames_drop(frames_drop),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic last; logic [7:0] data; } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer as a queue, speculative tail count, tx schedule by time.
    ent_t       mq[$];
    int         m_spec, m_cframes, m_cyc, m_next_ok;
    bit         m_armed, m_discard, m_hold_vld, m_sending;
    logic [7:0] m_hold;
    logic [7:0] e_txd;
    bit         e_tx_en, e_ovf;
    int         e_fwd, e_drop, e_level;

    logic [8:0] stim[$];
    logic [7:0] txq[$];

    task automatic model_edge(input logic r, input logic dv, input logic [7:0] d);
        int   occ;
        ent_t e;
        bit   hit;
        if (!r) begin
            mq.delete(); m_spec = 0; m_cframes = 0; m_next_ok = 0;
            m_armed = 0; m_discard = 0; m_hold_vld = 0; m_hold = 8'h00; m_sending = 0;
            e_txd = 8'h00; e_tx_en = 0; e_ovf = 0; e_fwd = 0; e_drop = 0; e_level = 0;
            return;
        end
        m_cyc++;
        occ = mq.size();
        e_ovf = 0;
        e_tx_en = 0;
        if (!m_sending && m_cyc >= m_next_ok && m_cframes > 0) m_sending = 1;
        if (m_sending) begin
            e = mq.pop_front();
            e_txd = e.data;
            e_tx_en = 1;
            if (e.last) begin
                m_sending = 0;
                m_cframes--;
                if (e_fwd < 65535) e_fwd++;
                m_next_ok = m_cyc + IFG + 1;
            end
        end
        hit = m_hold_vld && (occ == DEPTH);
        if (hit) begin
            repeat (m_spec) void'(mq.pop_back());
            m_spec = 0;
            e_ovf = 1;
            if (e_drop < 65535) e_drop++;
        end else if (m_hold_vld) begin
            e.last = !dv;
            e.data = m_hold;
            mq.push_back(e);
            if (dv) m_spec++;
            else begin
                m_spec = 0;
                m_cframes++;
            end
        end
        if (!m_armed) begin
            m_armed = !dv;
            m_hold_vld = 0;
        end else if (hit || m_discard) begin
            m_discard = dv;
            m_hold_vld = 0;
        end else begin
            m_discard = 0;
            m_hold_vld = dv;
            if (dv) m_hold = d;
        end
        e_level = mq.size();
    endtask

    task automatic tick(input logic r, input logic dv, input logic [7:0] d);
        rst_n = r; rx_dv = dv; rxd = d;
        @(posedge clk);
        model_edge(r, dv, d);
        @(negedge clk);
    endtask

    task automatic add_frame(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] v;
        v = base;
        for (int k = 0; k < n; k++) begin
            stim.push_back({1'b1, v});
            v = v + step;
        end
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) stim.push_back(9'h000);
    endtask

    task automatic restart();
        stim.delete();
        txq.delete();
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 8'hA5);
        checks++;
        if ({tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop} !== 46'd0) begin
            errors++;
            $display("FAIL reset_state: tx_en=%b txd=%h ovf=%b lvl=%0d fwd=%0d drop=%0d, all must be 0",
                     tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_b[3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        restart();
        add_frame(3, 8'h11, 8'h11);
        add_idle(8);
        foreach (stim[i]) begin
            tick(1'b1, stim[i][8], stim[i][7:0]);
            checks++;
            if ({tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop} !== {e_tx_en, e_txd, e_ovf, 4'(e_level), 16'(e_fwd), 16'(e_drop)}) begin
                errors++;
                $display("FAIL single_model edge=%0d got en=%b txd=%h ovf=%b lvl=%0d fwd=%0d drop=%0d exp en=%b txd=%h ovf=%b lvl=%0d fwd=%0d drop=%0d",
                         i, tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop, e_tx_en, e_txd, e_ovf, e_level, e_fwd, e_drop);
            end
            checks++;
            if (tx_en !== (i >= 4 && i <= 6) || (i >= 4 && i <= 6 && txd !== exp_b[(i >= 4 && i <= 6) ? i - 4 : 0])) begin
                errors++;
                $display("FAIL single_timing edge=%0d tx_en=%b txd=%h", i, tx_en, txd);
            end
        end
        checks++;
        if (frames_fwd !== 16'd1 || frames_drop !== 16'd0) begin
            errors++;
            $display("FAIL single_counts fwd=%0d drop=%0d, required 1 and 0", frames_fwd, frames_drop);
        end
    endtask

    task automatic test_back_to_back();
        restart();
        add_frame(4, 8'hA0, 8'h01);
        add_idle(1);
        add_frame(4, 8'hB0, 8'h01);
        add_idle(10);
        foreach (stim[i]) begin
            tick(1'b1, stim[i][8], stim[i][7:0]);
            if (tx_en) txq.push_back(txd);
            checks++;
            if (tx_en !== ((i >= 5 && i <= 8) || (i >= 11 && i <= 14))) begin
                errors++;
                $display("FAIL b2b_gap edge=%0d tx_en=%b", i, tx_en);
            end
        end
        checks++;
        if (txq.size() != 8 || frames_fwd !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count beats=%0d fwd=%0d, required 8 and 2", txq.size(), frames_fwd);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (txq[k] !== ((k < 4) ? 8'(8'hA0 + k) : 8'(8'hB0 + k - 4))) begin
                    errors++;
                    $display("FAIL b2b_order beat=%0d got=%h", k, txq[k]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        restart();
        add_frame(10, 8'h40, 8'h01);
        add_idle(2);
        add_frame(3, 8'h60, 8'h01);
        add_idle(10);
        foreach (stim[i]) begin
            tick(1'b1, stim[i][8], stim[i][7:0]);
            if (tx_en) txq.push_back(txd);
            if (overflow) begin
                pulses++;
                checks++;
                if (fifo_level !== 4'd0) begin
                    errors++;
                    $display("FAIL ovf_level edge=%0d lvl=%0d, required 0", i, fifo_level);
                end
            end
            checks++;
            if ({tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop} !== {e_tx_en, e_txd, e_ovf, 4'(e_level), 16'(e_fwd), 16'(e_drop)}) begin
                errors++;
                $display("FAIL ovf_model edge=%0d got en=%b txd=%h ovf=%b lvl=%0d exp en=%b txd=%h ovf=%b lvl=%0d",
                         i, tx_en, txd, overflow, fifo_level, e_tx_en, e_txd, e_ovf, e_level);
            end
        end
        checks++;
        if (pulses != 1 || frames_drop !== 16'd1 || frames_fwd !== 16'd1 || txq.size() != 3 ||
            (txq.size() == 3 && (txq[0] !== 8'h60 || txq[1] !== 8'h61 || txq[2] !== 8'h62))) begin
            errors++;
            $display("FAIL ovf_result pulses=%0d drop=%0d fwd=%0d beats=%0d, required 1,1,1,3 (60 61 62)",
                     pulses, frames_drop, frames_fwd, txq.size());
        end
    endtask

    task automatic test_gap_stall();
        restart();
        add_frame(5, 8'h70, 8'h01);
        add_idle(1);
        add_frame(6, 8'h80, 8'h01);
        add_idle(20);
        foreach (stim[i]) begin
            tick(1'b1, stim[i][8], stim[i][7:0]);
            if (tx_en) txq.push_back(txd);
            checks++;
            if ({tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop} !== {e_tx_en, e_txd, e_ovf, 4'(e_level), 16'(e_fwd), 16'(e_drop)}) begin
                errors++;
                $display("FAIL stall_model edge=%0d got en=%b txd=%h ovf=%b lvl=%0d exp en=%b txd=%h ovf=%b lvl=%0d",
                         i, tx_en, txd, overflow, fifo_level, e_tx_en, e_txd, e_ovf, e_level);
            end
        end
        checks++;
        if (txq.size() < 5 || frames_fwd + frames_drop !== 16'd2 ||
            (txq.size() >= 5 && (txq[0] !== 8'h70 || txq[4] !== 8'h74))) begin
            errors++;
            $display("FAIL stall_first beats=%0d fwd=%0d drop=%0d, first frame 70..74 required",
                     txq.size(), frames_fwd, frames_drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        stim.delete();
        txq.delete();
        tick(1'b0, 1'b1, 8'h55);
        add_frame(3, 8'h56, 8'h01);
        add_idle(1);
        add_frame(3, 8'h90, 8'h01);
        add_idle(10);
        foreach (stim[i]) begin
            tick(1'b1, stim[i][8], stim[i][7:0]);
            if (tx_en) txq.push_back(txd);
        end
        checks++;
        if (frames_fwd !== 16'd1 || txq.size() != 3 ||
            (txq.size() == 3 && (txq[0] !== 8'h90 || txq[1] !== 8'h91 || txq[2] !== 8'h92))) begin
            errors++;
            $display("FAIL midreset fwd=%0d beats=%0d, required 1 and 90 91 92", frames_fwd, txq.size());
        end
    endtask

    task automatic test_reset_in_send();
        int n = 0;
        restart();
        add_frame(6, 8'hC0, 8'h01);
        add_idle(1);
        foreach (stim[i]) tick(1'b1, stim[i][8], stim[i][7:0]);
        while (!tx_en && n < 20) begin
            tick(1'b1, 1'b0, 8'h00);
            n++;
        end
        checks++;
        if (!tx_en) begin
            errors++;
            $display("FAIL send_timeout tx_en never rose within 20 cycles");
        end
        tick(1'b0, 1'b0, 8'h00);
        checks++;
        if ({tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop} !== 46'd0) begin
            errors++;
            $display("FAIL send_reset tx_en=%b txd=%h lvl=%0d fwd=%0d drop=%0d, all must be 0",
                     tx_en, txd, fifo_level, frames_fwd, frames_drop);
        end
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b0, 8'h00);
            checks++;
            if (tx_en !== 1'b0 || fifo_level !== 4'd0) begin
                errors++;
                $display("FAIL send_after cyc=%0d tx_en=%b lvl=%0d, required 0 and 0", k, tx_en, fifo_level);
            end
        end
    endtask

    task automatic test_random();
        int nframes = 0;
        int pulses = 0;
        restart();
        for (int f = 0; f < 30; f++) begin
            add_frame($urandom_range(1, 11), 8'($urandom), 8'($urandom_range(1, 255)));
            add_idle($urandom_range(1, 3));
            nframes++;
        end
        add_idle(60);
        foreach (stim[i]) begin
            tick(1'b1, stim[i][8], stim[i][7:0]);
            if (overflow) pulses++;
            checks++;
            if ({tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop} !== {e_tx_en, e_txd, e_ovf, 4'(e_level), 16'(e_fwd), 16'(e_drop)}) begin
                errors++;
                $display("FAIL rand_model edge=%0d got en=%b txd=%h ovf=%b lvl=%0d fwd=%0d drop=%0d exp en=%b txd=%h ovf=%b lvl=%0d fwd=%0d drop=%0d",
                         i, tx_en, txd, overflow, fifo_level, frames_fwd, frames_drop, e_tx_en, e_txd, e_ovf, e_level, e_fwd, e_drop);
            end
        end
        checks++;
        if (32'(frames_fwd) + 32'(frames_drop) != nframes || 32'(frames_drop) != pulses || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL rand_totals fwd=%0d drop=%0d pulses=%0d lvl=%0d frames=%0d",
                     frames_fwd, frames_drop, pulses, fifo_level, nframes);
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_dv = 1'b0; rxd = 8'h00;
        m_cyc = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_gap_stall();
        test_reset_mid_frame();
        test_reset_in_send();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
